// File: rtl/uart_tx_sched.sv
// Round-robin 8N1 transmitter shared by two byte requesters.
// One frame is start, 8 data bits LSB first, stop; each bit lasts BAUD_DIV cycles.
module uart_tx_sched #(
   parameter int BAUD_DIV = 10408,
   parameter int CNT_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       ack0,
   output logic       ack1,
   output logic       busy,
   output logic       grant_id,
   output logic       txd
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             last_q, last_d;
   logic             gid_q, gid_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             busy_q, busy_d;
   logic             txd_q, txd_d;

   logic             any_req;
   logic             pick1;
   logic [7:0]       pick_data;
   logic             bit_end;
   logic             grant_en;

   // Requester 1 wins alone, or on a tie when requester 0 was served last.
   assign any_req   = req0_valid | req1_valid;
   assign pick1     = req1_valid & (~req0_valid | ~last_q);
   assign pick_data = pick1 ? req1_data : req0_data;
   assign bit_end   = (cnt_q == '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      last_d   = last_q;
      gid_d    = gid_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      busy_d   = busy_q;
      txd_d    = txd_q;
      grant_en = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d    = RELOAD;
            txd_d    = 1'b1;
            busy_d   = 1'b0;
            grant_en = any_req;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               cnt_d   = RELOAD;
               bit_d   = 3'd0;
               txd_d   = shift_q[0];
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
                  txd_d   = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = RELOAD;
               if (any_req) begin
                  grant_en = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  txd_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Grant from IDLE or straight out of the stop bit: no idle gap.
      if (grant_en) begin
         state_d = START;
         cnt_d   = RELOAD;
         bit_d   = 3'd0;
         shift_d = pick_data;
         gid_d   = pick1;
         last_d  = pick1;
         ack0_d  = ~pick1;
         ack1_d  = pick1;
         busy_d  = 1'b1;
         txd_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= RELOAD;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         last_q  <= 1'b1;
         gid_q   <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         txd_q   <= txd_d;
      end
   end

   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign busy     = busy_q;
   assign grant_id = gid_q;
   assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: frame-level reference model plus table and
// hand-written sequences, run with a short bit period.
module tb_uart_tx_sched;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       v0 = 1'b0;
   logic       v1 = 1'b0;
   logic [7:0] d0 = 8'h00;
   logic [7:0] d1 = 8'h00;
   logic       ack0, ack1, busy, grant_id, txd;

   always #5 clk = ~clk;

   uart_tx_sched #(.BAUD_DIV(D), .CNT_W(16)) dut (
      .clk(clk),
      .rst(rst),
      .req0_valid(v0),
      .req0_data(d0),
      .req1_valid(v1),
      .req1_data(d1),
      .ack0(ack0),
      .ack1(ack1),
      .busy(busy),
      .grant_id(grant_id),
      .txd(txd)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: a frame is a 10-bit pattern shown for 10*D cycles;
   // requests are looked at only when no frame cycles remain after the edge.
   int         m_left = 0;
   int         m_pos = 0;
   logic [9:0] m_frame = 10'h3ff;
   logic       m_last = 1'b1;
   logic       m_gid = 1'b0;
   logic       m_a0 = 1'b0;
   logic       m_a1 = 1'b0;
   logic       m_w;

   always @(posedge clk) begin
      if (!rst) begin
         m_left = 0;
         m_pos  = 0;
         m_last = 1'b1;
         m_gid  = 1'b0;
         m_a0   = 1'b0;
         m_a1   = 1'b0;
      end else begin
         m_a0 = 1'b0;
         m_a1 = 1'b0;
         if (m_left > 0) begin
            m_left--;
            m_pos++;
         end
         if (m_left == 0 && (v0 || v1)) begin
            m_w     = (v0 && v1) ? ~m_last : v1;
            m_frame = {1'b1, (m_w ? d1 : d0), 1'b0};
            m_left  = 10 * D;
            m_pos   = 0;
            m_gid   = m_w;
            m_last  = m_w;
            m_a0    = ~m_w;
            m_a1    = m_w;
         end
      end
   end

   logic chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_txd", txd, (m_left > 0) ? m_frame[m_pos / D] : 1'b1);
         check("model_busy", busy, (m_left > 0) ? 1 : 0);
         check("model_ack0", ack0, m_a0);
         check("model_ack1", ack1, m_a1);
         check("model_grant", grant_id, m_gid);
         check("ack_overlap", ack0 & ack1, 0);
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      v0  = 1'b0;
      v1  = 1'b0;
      tick(2);
      rst = 1'b1;
   endtask

   task automatic wait_ack();
      int i;
      for (i = 0; i < 100; i++) begin
         tick(1);
         if (ack0 || ack1) break;
      end
      if (i == 100) check("ack_timeout", 0, 1);
   endtask

   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       gid;
      logic [7:0] byt;
   } vec_t;

   vec_t vecs[5];
   logic samples[10*D];
   logic [7:0] got;
   int   nbusy;
   int   na1;
   logic exp_g;

   initial begin
      vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C};
      vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
      vecs[3] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00};

      tick(2);
      chk_en = 1'b1;
      check("rst_txd", txd, 1);
      check("rst_busy", busy, 0);
      check("rst_ack", {ack1, ack0}, 0);
      check("rst_grant", grant_id, 0);
      rst = 1'b1;

      // Single frames from reset, decoded from the line.
      for (int t = 0; t < 5; t++) begin
         do_reset();
         tick(1);
         v0 = vecs[t].v0;
         d0 = vecs[t].d0;
         v1 = vecs[t].v1;
         d1 = vecs[t].d1;
         wait_ack();
         check("tbl_grant", grant_id, vecs[t].gid);
         check("tbl_ack", {ack1, ack0}, vecs[t].gid ? 2 : 1);
         v0 = 1'b0;
         v1 = 1'b0;
         d0 = ~d0;
         d1 = ~d1;
         nbusy = 0;
         for (int i = 0; i < 10*D; i++) begin
            if (i > 0) tick(1);
            samples[i] = txd;
            if (busy) nbusy++;
         end
         for (int k = 0; k < 8; k++) got[k] = samples[(k+1)*D + 1];
         check("tbl_start", samples[1], 0);
         check("tbl_byte", got, vecs[t].byt);
         check("tbl_stop", samples[9*D + 1], 1);
         check("tbl_busy_len", nbusy, 10*D);
         tick(1);
         check("tbl_idle_busy", busy, 0);
      end

      // Both valid and held: 0x11 then 0x22 with no idle cycle.
      do_reset();
      tick(1);
      v0 = 1'b1; d0 = 8'h11;
      v1 = 1'b1; d1 = 8'h22;
      wait_ack();
      check("b2b_first", {ack1, ack0}, 1);
      v0 = 1'b0;
      tick(10*D);
      check("b2b_ack1", ack1, 1);
      check("b2b_txd", txd, 0);
      check("b2b_grant", grant_id, 1);
      v1 = 1'b0;
      tick(10*D + 5);

      // Continuous contention alternates the grant.
      do_reset();
      tick(1);
      v0 = 1'b1; d0 = 8'($urandom);
      v1 = 1'b1; d1 = 8'($urandom);
      for (int f = 0; f < 4; f++) begin
         wait_ack();
         exp_g = f[0];
         check("alt_grant", grant_id, exp_g);
         if (ack0) v0 = 1'b0; else v1 = 1'b0;
         tick(1);
         if (!v0) begin v0 = 1'b1; d0 = 8'($urandom); end
         if (!v1) begin v1 = 1'b1; d1 = 8'($urandom); end
      end
      v0 = 1'b0;
      v1 = 1'b0;
      tick(10*D + 5);

      // Reset during data bit 3 drops the frame at once.
      do_reset();
      tick(1);
      v0 = 1'b1; d0 = 8'h5A;
      wait_ack();
      v0 = 1'b0;
      tick(4*D + 1);
      rst = 1'b0;
      tick(1);
      check("rstmid_txd", txd, 1);
      check("rstmid_busy", busy, 0);
      check("rstmid_ack", {ack1, ack0}, 0);
      rst = 1'b1;
      tick(20);
      check("rstmid_idle_txd", txd, 1);
      check("rstmid_idle_busy", busy, 0);

      // A request pulse mid-frame is ignored.
      do_reset();
      tick(1);
      v0 = 1'b1; d0 = 8'hC3;
      wait_ack();
      v0 = 1'b0;
      na1 = 0;
      tick(10);
      v1 = 1'b1; d1 = 8'h77;
      for (int i = 0; i < 10; i++) begin tick(1); if (ack1) na1++; end
      v1 = 1'b0;
      for (int i = 0; i < 25; i++) begin tick(1); if (ack1) na1++; end
      check("glitch_no_ack1", na1, 0);
      check("glitch_idle", busy, 0);

      // A request held through the stop end is served back to back.
      v0 = 1'b1; d0 = 8'h12;
      wait_ack();
      v0 = 1'b0;
      tick(5);
      v1 = 1'b1; d1 = 8'h34;
      tick(10*D - 5);
      check("hold_ack1", ack1, 1);
      check("hold_txd", txd, 0);
      v1 = 1'b0;
      tick(10*D + 5);

      // Random traffic with occasional resets against the model.
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 799) != 0);
         v0  = ($urandom_range(0, 9) < 4);
         v1  = ($urandom_range(0, 9) < 4);
         d0  = 8'($urandom);
         d1  = 8'($urandom);
         tick(1);
      end
      rst = 1'b1;
      v0  = 1'b0;
      v1  = 1'b0;
      tick(10*D + 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
